// File: rtl/expansion_input_debounce.sv
// Synchronises the parallel word from the shift-register input expander and
// debounces every bit independently, publishing stable levels and edge strobes.
module expansion_input_debounce #(
  parameter int WIDTH        = 8,
  parameter int SAMPLE_DIV   = 1000,
  parameter int STABLE_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_COUNT - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             tick;

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
    data_d  = data_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        // any sample that agrees with the published level restarts the run
        if (sync2_q[i] == data_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          data_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      data_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      presc_q   <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw_in;
      sync2_q   <= sync1_q;
      data_q    <= data_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      presc_q   <= presc_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign data_out = data_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_expansion_input_debounce.sv
// Scoreboard bench: three debounce instances with different sample/stable
// settings; expected strobe events are queued with the stimulus that causes them.
module tb_expansion_input_debounce;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] raw_a = '0, raw_b = '0, raw_c = '0;
  logic [7:0] data_a, rise_a, fall_a, data_b, rise_b, fall_b, data_c, rise_c, fall_c;
  logic       chg_a, chg_b, chg_c;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    logic [7:0] r;
    logic [7:0] f;
    int         lo;
    int         hi;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  expansion_input_debounce #(.WIDTH(8), .SAMPLE_DIV(1), .STABLE_COUNT(3)) dut_a (
    .clk(clk), .reset(reset), .raw_in(raw_a), .data_out(data_a),
    .rise(rise_a), .fall(fall_a), .changed(chg_a));

  expansion_input_debounce #(.WIDTH(8), .SAMPLE_DIV(4), .STABLE_COUNT(2)) dut_b (
    .clk(clk), .reset(reset), .raw_in(raw_b), .data_out(data_b),
    .rise(rise_b), .fall(fall_b), .changed(chg_b));

  expansion_input_debounce #(.WIDTH(8), .SAMPLE_DIV(1), .STABLE_COUNT(1)) dut_c (
    .clk(clk), .reset(reset), .raw_in(raw_c), .data_out(data_c),
    .rise(rise_c), .fall(fall_c), .changed(chg_c));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic score(input int id, input logic [7:0] d, input logic [7:0] r,
                       input logic [7:0] f, input logic ch);
    exp_t e;
    bit   ok;
    if (ch || ((r | f) != 8'h00)) begin
      ok = 1'b0;
      case (id)
        0: if (qa.size() > 0) begin e = qa.pop_front(); ok = 1'b1; end
        1: if (qb.size() > 0) begin e = qb.pop_front(); ok = 1'b1; end
        default: if (qc.size() > 0) begin e = qc.pop_front(); ok = 1'b1; end
      endcase
      check($sformatf("strobe_expected_%0d", id), 32'(ok), 32'd1);
      if (ok) begin
        check($sformatf("data_%0d", id), 32'(d), 32'(e.d));
        check($sformatf("rise_%0d", id), 32'(r), 32'(e.r));
        check($sformatf("fall_%0d", id), 32'(f), 32'(e.f));
        check($sformatf("changed_%0d", id), 32'(ch), 32'd1);
        check($sformatf("edge_window_%0d_cyc%0d", id, cyc),
              32'((cyc >= e.lo) && (cyc <= e.hi)), 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      score(0, data_a, rise_a, fall_a, chg_a);
      score(1, data_b, rise_b, fall_b, chg_b);
      score(2, data_c, rise_c, fall_c, chg_c);
    end
  end

  task automatic wait_idle(input int max_cyc);
    for (int k = 0; k < max_cyc && (qa.size() + qb.size() + qc.size()) > 0; k++)
      @(negedge clk);
    repeat (8) @(negedge clk);
    check("queue_a_drained", 32'(qa.size()), 32'd0);
    check("queue_b_drained", 32'(qb.size()), 32'd0);
    check("queue_c_drained", 32'(qc.size()), 32'd0);
    qa.delete();
    qb.delete();
    qc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int maxc;
    repeat (3) @(negedge clk);
    check("rst_data_a", 32'(data_a), 32'd0);
    check("rst_data_b", 32'(data_b), 32'd0);
    check("rst_data_c", 32'(data_c), 32'd0);
    check("rst_strobes", 32'(rise_a | fall_a | rise_b | fall_b | rise_c | fall_c), 32'd0);
    check("rst_changed", 32'({chg_a, chg_b, chg_c}), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // bounce: bit0 high for two cycles only, never accepted with three samples
    raw_a = 8'h01;
    repeat (2) @(negedge clk);
    raw_a = 8'h00;
    wait_idle(20);
    check("bounce_data_a", 32'(data_a), 32'h00);

    // held step on bit0: accepted on edge 2+3 after the change
    n = cyc;
    raw_a = 8'h01;
    qa.push_back('{d: 8'h01, r: 8'h01, f: 8'h00, lo: n + 5, hi: n + 5});
    wait_idle(20);
    check("step_data_a", 32'(data_a), 32'h01);

    // divided sampling: two ticks of four clocks, tick phase unknown to the stimulus
    n = cyc;
    raw_b = 8'hA5;
    qb.push_back('{d: 8'hA5, r: 8'hA5, f: 8'h00, lo: n + 7, hi: n + 10});
    wait_idle(20);
    n = cyc;
    raw_b = 8'h0F;
    qb.push_back('{d: 8'h0F, r: 8'h0A, f: 8'hA0, lo: n + 7, hi: n + 10});
    wait_idle(20);
    check("mixed_data_b", 32'(data_b), 32'h0F);

    // bit7 alternating once per tick period: every other sample agrees, no accept
    maxc = 0;
    for (int t = 0; t < 80; t++) begin
      if (t % 4 == 0) raw_b[7] = ~raw_b[7];
      @(negedge clk);
      if (int'(dut_b.cnt_q[7]) > maxc) maxc = int'(dut_b.cnt_q[7]);
    end
    raw_b[7] = 1'b0;
    wait_idle(20);
    check("toggle_cnt_max", 32'(maxc), 32'd1);
    check("toggle_data_b", 32'(data_b), 32'h0F);

    // single-sample acceptance
    n = cyc;
    raw_c = 8'hFF;
    qc.push_back('{d: 8'hFF, r: 8'hFF, f: 8'h00, lo: n + 3, hi: n + 3});
    wait_idle(20);
    check("fast_data_c", 32'(data_c), 32'hFF);

    // reset while a falling run on bit0 is one sample short of acceptance
    raw_a = 8'h00;
    repeat (4) @(negedge clk);
    check("pre_reset_cnt_a0", 32'(dut_a.cnt_q[0]), 32'd2);
    check("pre_reset_data_a", 32'(data_a), 32'h01);
    reset = 1'b1;
    #1;
    check("async_clr_data_a", 32'(data_a), 32'h00);
    check("async_clr_data_b", 32'(data_b), 32'h00);
    check("async_clr_data_c", 32'(data_c), 32'h00);
    check("async_clr_cnt_a0", 32'(dut_a.cnt_q[0]), 32'd0);
    raw_a = 8'h01;
    raw_b = 8'h0F;
    raw_c = 8'h00;
    repeat (3) @(negedge clk);
    n = cyc;
    reset = 1'b0;
    qa.push_back('{d: 8'h01, r: 8'h01, f: 8'h00, lo: n + 5, hi: n + 5});
    qb.push_back('{d: 8'h0F, r: 8'h0F, f: 8'h00, lo: n + 7, hi: n + 10});
    wait_idle(30);
    check("post_reset_data_a", 32'(data_a), 32'h01);
    check("post_reset_data_b", 32'(data_b), 32'h0F);
    check("post_reset_data_c", 32'(data_c), 32'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
